sigma_delta_adc: RTL

SIGMA_DELTA_ADC -- requirements
Module: sigma_delta_adc

---
 rtl/sigma_delta_adc.sv | 89 ++++++++
 1 files changed

// File: rtl/sigma_delta_adc.sv
// First-order sigma-delta ADC back end: synchronizes the external comparator,
// drives the 1-bit feedback stream, and box-car decimates it into 15-bit excess-2^14 samples.
module sigma_delta_adc #(
    parameter int unsigned OSR_LOG2 = 8,
    parameter logic [14:0] HYST_HI  = 15'h5000,
    parameter logic [14:0] HYST_LO  = 15'h3000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CompIn,
    output logic        FbOut,
    output logic [14:0] Sample,
    output logic        SampleValid,
    output logic        Ear
);

    localparam logic [OSR_LOG2-1:0] WIN_LAST   = '1;
    localparam logic [OSR_LOG2:0]   FULL_SCALE = {1'b1, {OSR_LOG2{1'b0}}};
    localparam int                  SHIFT      = 15 - OSR_LOG2;

    // A window of all ones would wrap to zero once shifted into 15 bits; clamp it to full scale.
    function automatic logic [14:0] scale_sat(input logic [OSR_LOG2:0] total);
        logic [14:0] shifted;
        shifted = 15'(total) << SHIFT;
        if (total == FULL_SCALE)
            return 15'h7FFF;
        return shifted;
    endfunction

    function automatic logic ear_hyst(input logic [14:0] smp, input logic cur);
        if (smp >= HYST_HI)
            return 1'b1;
        if (smp <= HYST_LO)
            return 1'b0;
        return cur;
    endfunction

    logic                r_s1;
    logic                r_s2;
    logic                r_fb;
    logic [OSR_LOG2-1:0] r_win_cnt;
    logic [OSR_LOG2:0]   r_acc;
    logic [14:0]         r_sample;
    logic                r_valid;
    logic                r_ear;

    logic                w_terminal;
    logic [OSR_LOG2:0]   w_total;
    logic [14:0]         w_sample_new;
    logic                w_ear_new;

    assign w_terminal   = (r_win_cnt == WIN_LAST);
    assign w_total      = r_acc + {{OSR_LOG2{1'b0}}, r_fb};
    assign w_sample_new = scale_sat(w_total);
    assign w_ear_new    = ear_hyst(w_sample_new, r_ear);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_fb      <= 1'b0;
            r_win_cnt <= '0;
            r_acc     <= '0;
            r_sample  <= 15'h4000;
            r_valid   <= 1'b0;
            r_ear     <= 1'b0;
        end else begin
            r_s1      <= CompIn;
            r_s2      <= r_s1;
            r_fb      <= r_s2;
            r_win_cnt <= r_win_cnt + 1'b1;
            if (w_terminal) begin
                r_acc    <= '0;
                r_valid  <= 1'b1;
                r_sample <= w_sample_new;
                r_ear    <= w_ear_new;
            end else begin
                r_acc    <= w_total;
                r_valid  <= 1'b0;
            end
        end
    end

    assign FbOut       = r_fb;
    assign Sample      = r_sample;
    assign SampleValid = r_valid;
    assign Ear         = r_ear;

endmodule
